// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage
// ----------------------------------------------------------------------------
// Instruction-fetch front end sitting directly upstream of decode.
// Owns the program counter, drives a synchronous-read instruction memory with
// a fixed one-cycle read latency, buffers returned words in a two-entry queue
// and presents {instr, instr_pc} to decode over a valid/ready handshake.
// Taken branches/jumps from execute redirect the fetch stream and flush any
// younger work already fetched.
//
// Ports
//   clk             in   system clock, rising edge
//   rst             in   asynchronous active-high reset
//   halt            in   suppresses new memory requests (buffer still drains)
//   redirect_valid  in   taken branch/jump from execute
//   redirect_pc     in   redirect target address
//   imem_req        out  instruction memory read request this cycle
//   imem_addr       out  instruction memory read address
//   imem_rdata      in   read data, valid the cycle after imem_req
//   instr_valid     out  queue head holds a valid instruction
//   instr_ready     in   decode accepts the head this cycle
//   instr           out  head instruction word
//   instr_pc        out  PC of the head instruction
// ============================================================================
module fetch_stage #(
    parameter int              A_WIDTH  = 32,
    parameter logic [A_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt,
    input  logic               redirect_valid,
    input  logic [A_WIDTH-1:0] redirect_pc,
    output logic               imem_req,
    output logic [A_WIDTH-1:0] imem_addr,
    input  logic [A_WIDTH-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [A_WIDTH-1:0] instr,
    output logic [A_WIDTH-1:0] instr_pc
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [A_WIDTH-1:0] fetchPc_q,    fetchPc_d;
    logic [1:0]         count_q,      count_d;
    logic               rdPtr_q,      rdPtr_d;
    logic               wrPtr_q,      wrPtr_d;
    logic               inflight_q,   inflight_d;
    logic [A_WIDTH-1:0] inflightPc_q, inflightPc_d;
    logic               kill_q,       kill_d;

    logic [A_WIDTH-1:0] bufInstr_q [2];
    logic [A_WIDTH-1:0] bufPc_q    [2];

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic pop;
    logic push;
    logic hasRoom;
    logic [2:0] occupied;
    logic [2:0] limit;

    // Head presentation: the queue is never bypassed, so decode always sees a
    // registered entry. A redirect hides the head because it is about to be
    // flushed as wrong-path work.
    always_comb begin
        instr_valid = (count_q != 2'd0) & ~redirect_valid;
        instr       = bufInstr_q[rdPtr_q];
        instr_pc    = bufPc_q[rdPtr_q];
        pop         = instr_valid & instr_ready;
    end

    // Request generation. A request is only issued if the response it will
    // produce next cycle is guaranteed a free slot: entries held plus the
    // response already in flight, minus the entry leaving this cycle, must
    // be below two. A redirect bypasses the room check because the queue is
    // flushed on the same edge.
    always_comb begin
        occupied  = {1'b0, count_q} + {2'b00, inflight_q};
        limit     = 3'd2 + {2'b00, pop};
        hasRoom   = occupied < limit;
        imem_req  = ~rst & ~halt & (redirect_valid | hasRoom);
        imem_addr = (redirect_valid & ~rst) ? redirect_pc : fetchPc_q;
    end

    // A returning word is written into the queue unless it belongs to a
    // stream that has just been redirected away from, either because the
    // redirect is happening right now or because the kill marker is set.
    always_comb begin
        push = inflight_q & ~kill_q & ~redirect_valid;
    end

    // ------------------------------------------------------------------------
    // Next-state logic for PC, request tracking and queue bookkeeping.
    // ------------------------------------------------------------------------
    always_comb begin
        fetchPc_d    = fetchPc_q;
        inflight_d   = 1'b0;
        inflightPc_d = inflightPc_q;
        kill_d       = 1'b0;
        count_d      = count_q;
        rdPtr_d      = rdPtr_q;
        wrPtr_d      = wrPtr_q;

        // The PC advances past whatever address was actually requested, so a
        // redirect that issues immediately continues at target + 4.
        if (imem_req) begin
            fetchPc_d    = imem_addr + A_WIDTH'(4);
            inflight_d   = 1'b1;
            inflightPc_d = imem_addr;
        end else if (redirect_valid) begin
            fetchPc_d = redirect_pc;
        end

        if (redirect_valid) begin
            // Flush everything. If a response was pending and no fresh
            // request replaces it, mark the slot so nothing stale can land.
            count_d = 2'd0;
            rdPtr_d = 1'b0;
            wrPtr_d = 1'b0;
            kill_d  = inflight_q & ~imem_req;
        end else begin
            // Simultaneous push and pop leave the count unchanged while both
            // pointers advance; the pointers wrap naturally at one bit.
            if (push) begin
                wrPtr_d = ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_d = ~rdPtr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc_q    <= RESET_PC;
            count_q      <= 2'd0;
            rdPtr_q      <= 1'b0;
            wrPtr_q      <= 1'b0;
            inflight_q   <= 1'b0;
            inflightPc_q <= '0;
            kill_q       <= 1'b0;
        end else begin
            fetchPc_q    <= fetchPc_d;
            count_q      <= count_d;
            rdPtr_q      <= rdPtr_d;
            wrPtr_q      <= wrPtr_d;
            inflight_q   <= inflight_d;
            inflightPc_q <= inflightPc_d;
            kill_q       <= kill_d;
        end
    end

    // ------------------------------------------------------------------------
    // Queue storage. Entries are cleared on reset so the head outputs read
    // zero until the first instruction arrives.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                bufInstr_q[i] <= '0;
                bufPc_q[i]    <= '0;
            end
        end else if (push) begin
            bufInstr_q[wrPtr_q] <= imem_rdata;
            bufPc_q[wrPtr_q]    <= inflightPc_q;
        end
    end

endmodule
